// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake between uart_rx/uart_tx and the transmit arbiter.
// master = arbiter side (drives tx_start/tx_data), slave = UART side.
interface uart_tx_arbiter_if;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (input rx_done_tick, rx_data, tx_done_tick, output tx_start, tx_data);
  modport slave  (output rx_done_tick, rx_data, tx_done_tick, input tx_start, tx_data);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between rx echo (FIFO-buffered) and an
// atomic hex report frame of the rx byte count. Define UART_ARB_CRLF_EN to append CR/LF.
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_tx_arbiter_if.master   bus,
  input  logic                loopback_en,
  input  logic                report_req,
  output logic [7:0]          rx_count,
  output logic                fifo_overflow,
  output logic                busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_ARB_CRLF_EN
  localparam logic [1:0] LAST = 2'd3;
`else
  localparam logic [1:0] LAST = 2'd1;
`endif

  typedef enum logic [1:0] {IDLE, ECHO_WAIT, REP_LOAD, REP_WAIT} state_t;
  typedef enum logic {GR_ECHO, GR_REPORT} grant_t;

  state_t      state, state_nxt;
  grant_t      last_grant;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop, drop;
  logic        report_pending, in_report;
  logic [7:0]  snap;
  logic [1:0]  idx;
  logic        grant_echo, grant_rep, load_next;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [7:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return hex(v[7:4]);
      2'd1:    return hex(v[3:0]);
      2'd2:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = grant_echo;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push      = bus.rx_done_tick & loopback_en & (~full | pop);
  assign drop      = bus.rx_done_tick & loopback_en & full & ~pop;
  assign in_report = (state == REP_LOAD) || (state == REP_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_echo = 1'b0;
    grant_rep  = 1'b0;
    load_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && (!report_pending || last_grant == GR_REPORT)) begin
          grant_echo = 1'b1;
          state_nxt  = ECHO_WAIT;
        end else if (report_pending) begin
          grant_rep = 1'b1;
          state_nxt = REP_LOAD;
        end
      end
      ECHO_WAIT: if (bus.tx_done_tick) state_nxt = IDLE;
      REP_LOAD:  state_nxt = REP_WAIT;
      REP_WAIT: begin
        if (bus.tx_done_tick) begin
          if (idx == LAST) state_nxt = IDLE;
          else begin
            load_next = 1'b1;
            state_nxt = REP_LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_start is registered off the grant/advance, so it coincides with ECHO_WAIT entry
  // or with the single REP_LOAD cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_start_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      snap           <= 8'h00;
      idx            <= 2'd0;
      last_grant     <= GR_REPORT;
      report_pending <= 1'b0;
      rx_count       <= 8'h00;
      fifo_overflow  <= 1'b0;
    end else begin
      tx_start_q <= grant_echo | grant_rep | load_next;
      if (grant_echo)     tx_data_q <= mem[rd_ptr[AW-1:0]];
      else if (grant_rep) tx_data_q <= frame_byte(rx_count, 2'd0);
      else if (load_next) tx_data_q <= frame_byte(snap, idx + 2'd1);
      if (grant_rep) begin
        snap <= rx_count;
        idx  <= 2'd0;
      end else if (load_next) begin
        idx <= idx + 2'd1;
      end
      if (grant_echo)     last_grant <= GR_ECHO;
      else if (grant_rep) last_grant <= GR_REPORT;
      if (grant_rep)                      report_pending <= 1'b0;
      else if (report_req && !in_report)  report_pending <= 1'b1;
      if (bus.rx_done_tick) rx_count <= rx_count + 8'd1;
      if (drop)             fifo_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (!loopback_en) rd_ptr <= wr_ptr;
      else if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.rx_data;
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign busy         = (state != IDLE);
endmodule
